nibble_serial_addsub: RTL and testbench

- Multi-cycle sequencer for NIBBLES*4-bit add/subtract, built on a single shared 4-bit ripple full-adder slice.
- Processes one nibble per clock, LSB nibble first, and holds carry/borrow in a register between nibbles.
- Subtract is performed as A + ~B + 1: B is inverted at capture and the initial carry is 1.
- Provides wide arithmetic to the rest of the design without instantiating a wide adder.

---
 rtl/nibble_serial_addsub.sv | 115 +++++++++++
 tb/tb_nibble_serial_addsub.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub.sv
// ============================================================================
// Module   : nibble_serial_addsub
// Purpose  : NIBBLES*4-bit add/subtract computed one nibble per clock on a
//            single shared 4-bit slice, LSB nibble first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 op_sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 overflow,
    output logic                 zero,
    output logic                 done
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_op_a;
    logic [W-1:0]    r_op_b;
    logic            r_carry;
    logic [IDXW-1:0] r_idx;

    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [4:0]      w_sum5;
    logic [3:0]      w_low4;
    logic            w_c3;
    logic [W-1:0]    w_next_result;

    // Shared slice; the 3-bit partial sum exposes the carry into bit 3 for overflow.
    always_comb begin
        w_a_nib = r_op_a[{r_idx, 2'b00} +: 4];
        w_b_nib = r_op_b[{r_idx, 2'b00} +: 4];
        w_sum5  = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
        w_low4  = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, r_carry};
        w_c3    = w_low4[3];
        w_next_result = result;
        w_next_result[{r_idx, 2'b00} +: 4] = w_sum5[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            start_ready <= 1'b1;
            done        <= 1'b0;
            result      <= '0;
            cout        <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_valid) begin
                        r_op_a      <= a;
                        r_op_b      <= op_sub ? ~b : b;
                        r_carry     <= op_sub;
                        r_idx       <= '0;
                        start_ready <= 1'b0;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    result  <= w_next_result;
                    r_carry <= w_sum5[4];
                    if (r_idx == c_last_idx) begin
                        cout     <= w_sum5[4];
                        overflow <= w_c3 ^ w_sum5[4];
                        zero     <= (w_next_result == '0);
                        done     <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    done        <= 1'b0;
                    start_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: begin
                    done        <= 1'b0;
                    start_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_addsub.sv
// ============================================================================
// Module   : tb_nibble_serial_addsub
// Purpose  : Directed vector table, random ops, busy/back-to-back and
//            mid-operation reset sequences against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_addsub;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic         done;

    int total = 0;
    int passed = 0;

    nibble_serial_addsub #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid),
        .start_ready(start_ready), .op_sub(op_sub), .a(a), .b(b),
        .result(result), .cout(cout), .overflow(overflow), .zero(zero),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         c;
        logic         ov;
        logic         z;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic, packed as {z, ov, c, res}.
    function automatic logic [W+2:0] model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint ua, ub, sa, sb, sr;
        logic [W-1:0] r;
        logic c, ov;
        ua = longint'(av);
        ub = longint'(bv);
        sa = (av[W-1]) ? ua - (longint'(1) << W) : ua;
        sb = (bv[W-1]) ? ub - (longint'(1) << W) : ub;
        if (s) begin
            r  = W'(ua - ub);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = W'(ua + ub);
            c  = ((ua + ub) >= (longint'(1) << W));
            sr = sa + sb;
        end
        ov = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
        return {(r == '0), ov, c, r};
    endfunction

    // One complete operation starting from IDLE, with latency and pulse checks.
    task automatic run_op(input string nm, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W+2:0] e;
        int lat;
        e = model(s, av, bv);
        @(negedge clk);
        chk({nm, " ready"}, 32'(start_ready), 32'd1);
        op_sub = s; a = av; b = bv; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(N));
        chk({nm, " result"}, 32'(result), 32'(e[W-1:0]));
        chk({nm, " flags{z,ov,c}"}, {29'd0, zero, overflow, cout}, {29'd0, e[W+2], e[W+1], e[W]});
        @(posedge clk); #1;
        chk({nm, " done pulse width"}, {30'd0, done, start_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    initial begin
        vec_t vecs[6];
        logic [W+2:0] q[$];
        logic [W+2:0] e;
        int last_done, cyc, ndone;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FF1, 16'h2225, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {result, 11'd0, cout, overflow, zero, done, start_ready},
            {16'h0000, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk); rst_n = 1'b1;

        // Directed table: expected values written by hand, also cross-checked against the model.
        foreach (vecs[i]) begin
            chk($sformatf("vec%0d model", i), 32'(model(vecs[i].sub, vecs[i].a, vecs[i].b)),
                32'({vecs[i].z, vecs[i].ov, vecs[i].c, vecs[i].res}));
            run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d table", i), {13'd0, zero, overflow, cout, result},
                {13'd0, vecs[i].z, vecs[i].ov, vecs[i].c, vecs[i].res});
        end

        for (int i = 0; i < 30; i++)
            run_op($sformatf("rand%0d", i), 1'($urandom), W'($urandom), W'($urandom));

        // Busy / back-to-back: start_valid held high, operands change every cycle.
        q = {};
        last_done = -1;
        ndone = 0;
        cyc = 0;
        while (cyc < 200 && (cyc < 60 || q.size() != 0)) begin
            @(negedge clk);
            if (cyc < 60) begin
                a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
                start_valid = 1'b1;
                if (start_ready) q.push_back(model(op_sub, a, b));
            end else begin
                start_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (q.size() == 0) begin
                    chk("b2b unexpected done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("b2b result+flags", 32'({zero, overflow, cout, result}), 32'(e));
                end
                if (last_done >= 0 && cyc < 60)
                    chk("b2b done period", 32'(cyc - last_done), 32'(N + 2));
                last_done = cyc;
            end
            cyc++;
        end
        chk("b2b drained", 32'(q.size()), 32'd0);
        chk("b2b op count", 32'(ndone >= 9), 32'd1);
        start_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Reset mid-operation.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; op_sub = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", {result, 11'd0, cout, overflow, zero, done, start_ready},
            {16'h0000, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midreset no done", 32'(ndone), 32'd0);
        run_op("post-reset", 1'b0, 16'h0003, 16'h0004);
        chk("post-reset value", 32'(result), 32'h0007);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
